// File: rtl/alu_pkg.sv
// Shared ALU arbiter types: ALUSel encodings, FSM states and the default datapath width.
package alu_pkg;

  localparam int unsigned DataWDefault = 32;

  typedef enum logic [3:0] {
    AluOr    = 4'b0000,
    AluAdd1  = 4'b0001,
    AluJalr  = 4'b0010,
    AluAdd3  = 4'b0011,
    AluSub   = 4'b0100,
    AluSltu  = 4'b0110,
    AluSrl   = 4'b0111,
    AluAdd   = 4'b1000,
    AluPassB = 4'b1001,
    AluXor   = 4'b1010,
    AluSra   = 4'b1011,
    AluSlt   = 4'b1100,
    AluSll   = 4'b1110,
    AluAnd   = 4'b1111
  } alu_sel_e;

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } arb_state_e;

endpackage

// File: rtl/alu_arb_dp.sv
// Combinational ALU datapath: operand muxing and ALUSel decode for the granted request.
module alu_arb_dp
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              asel,
  input  logic              bsel,
  input  logic [3:0]        alusel,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] sum;
  logic [4:0]        shamt;

  assign op_a  = asel ? pc : rs1;
  assign op_b  = bsel ? imm : rs2;
  assign sum   = op_a + op_b;
  assign shamt = op_b[4:0];

  always_comb begin
    result = '0;
    case (alu_sel_e'(alusel))
      AluAdd, AluAdd1, AluAdd3: result = sum;
      AluSub:   result = op_a - op_b;
      AluSll:   result = op_a << shamt;
      AluSrl:   result = op_a >> shamt;
      AluSra:   result = $unsigned($signed(op_a) >>> shamt);
      AluSlt:   result = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      AluSltu:  result = {{(DATA_W-1){1'b0}}, op_a < op_b};
      AluAnd:   result = op_a & op_b;
      AluOr:    result = op_a | op_b;
      AluXor:   result = op_a ^ op_b;
      // jalr target: sum with the low bit forced to zero
      AluJalr:  result = {sum[DATA_W-1:1], 1'b0};
      AluPassB: result = op_b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one ALU with a single registered result slot.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; default is fixed priority (req 0 wins).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_asel,
  input  logic [1:0]          req_bsel,
  input  logic [7:0]          req_alusel,
  input  logic [2*DATA_W-1:0] req_pc,
  input  logic [2*DATA_W-1:0] req_rs1,
  input  logic [2*DATA_W-1:0] req_rs2,
  input  logic [2*DATA_W-1:0] req_imm,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_data
);

  arb_state_e        state_q;
  logic              owner_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [1:0]        grant;
  logic              gidx;
  logic              accept;
  logic              accept_ok;
  logic              handshake;
  logic [DATA_W-1:0] alu_result;

`ifdef ALU_ARBITER_RR_EN
  logic last_grant_q;
`endif

  assign rsp_valid = (state_q == StHold) ? {owner_q, ~owner_q} : 2'b00;
  assign rsp_data  = rsp_data_q;
  assign handshake = |(rsp_valid & rsp_ready);
  assign accept_ok = (state_q == StIdle) || handshake;

  always_comb begin
    grant = 2'b00;
    // reset_n gates the grant so nothing is offered while reset is held
    if (reset_n && accept_ok) begin
`ifdef ALU_ARBITER_RR_EN
      if (req_valid == 2'b11) grant = last_grant_q ? 2'b01 : 2'b10;
      else                    grant = req_valid;
`else
      if (req_valid[0])      grant = 2'b01;
      else if (req_valid[1]) grant = 2'b10;
`endif
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign gidx      = grant[1];

  alu_arb_dp #(
    .DATA_W (DATA_W)
  ) u_dp (
    .asel   (req_asel[gidx]),
    .bsel   (req_bsel[gidx]),
    .alusel (gidx ? req_alusel[7:4] : req_alusel[3:0]),
    .pc     (gidx ? req_pc[2*DATA_W-1:DATA_W]  : req_pc[DATA_W-1:0]),
    .rs1    (gidx ? req_rs1[2*DATA_W-1:DATA_W] : req_rs1[DATA_W-1:0]),
    .rs2    (gidx ? req_rs2[2*DATA_W-1:DATA_W] : req_rs2[DATA_W-1:0]),
    .imm    (gidx ? req_imm[2*DATA_W-1:DATA_W] : req_imm[DATA_W-1:0]),
    .result (alu_result)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q    <= StHold;
            owner_q    <= gidx;
            rsp_data_q <= alu_result;
          end
        end
        StHold: begin
          if (accept) begin
            owner_q    <= gidx;
            rsp_data_q <= alu_result;
          end else if (handshake) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALU_ARBITER_RR_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    last_grant_q <= 1'b1;
    else if (accept) last_grant_q <= gidx;
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; expectations follow ALU_ARBITER_RR_EN.
module tb_alu_arbiter;

  localparam int unsigned DW = 32;

  logic          clock;
  logic          reset_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_asel;
  logic [1:0]    req_bsel;
  logic [7:0]    req_alusel;
  logic [2*DW-1:0] req_pc;
  logic [2*DW-1:0] req_rs1;
  logic [2*DW-1:0] req_rs2;
  logic [2*DW-1:0] req_imm;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_data;

  int checks;
  int errors;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t vecs [13];

  alu_arbiter #(
    .DATA_W (DW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_asel   (req_asel),
    .req_bsel   (req_bsel),
    .req_alusel (req_alusel),
    .req_pc     (req_pc),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setop(input int i, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b);
    req_asel[i]           = 1'b0;
    req_bsel[i]           = 1'b0;
    req_alusel[4*i +: 4]  = sel;
    req_rs1[DW*i +: DW]   = a;
    req_rs2[DW*i +: DW]   = b;
    req_pc[DW*i +: DW]    = '0;
    req_imm[DW*i +: DW]   = '0;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    req_valid  = 2'b11;
    req_asel   = '0;
    req_bsel   = '0;
    req_alusel = '0;
    req_pc     = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    req_imm    = '0;
    rsp_ready  = 2'b00;

    vecs[0]  = '{4'b1011, 32'h8000_0000, 32'd4,  32'hF800_0000};
    vecs[1]  = '{4'b1100, 32'hFFFF_FFFF, 32'd1,  32'd1};
    vecs[2]  = '{4'b0110, 32'hFFFF_FFFF, 32'd1,  32'd0};
    vecs[3]  = '{4'b0010, 32'd3,         32'd4,  32'd6};
    vecs[4]  = '{4'b0101, 32'd3,         32'd4,  32'd0};
    vecs[5]  = '{4'b0100, 32'd5,         32'd7,  32'hFFFF_FFFE};
    vecs[6]  = '{4'b1110, 32'd1,         32'd31, 32'h8000_0000};
    vecs[7]  = '{4'b0111, 32'h8000_0000, 32'd4,  32'h0800_0000};
    vecs[8]  = '{4'b1111, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
    vecs[9]  = '{4'b0000, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF};
    vecs[10] = '{4'b1010, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0};
    vecs[11] = '{4'b1001, 32'd3,         32'd9,  32'd9};
    vecs[12] = '{4'b1000, 32'hFFFF_FFFF, 32'd2,  32'd1};

    // Reset state, with requests offered to show they are not accepted.
    #2;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    cyc();
    cyc();
    reset_n   = 1'b1;
    req_valid = 2'b00;

    // Single op: 5 + 7.
    setop(0, 4'b1000, 32'd5, 32'd7);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    #1 chk("single_req_ready", 32'(req_ready), 32'd1);
    cyc();
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_data", rsp_data, 32'd12);
    req_valid = 2'b00;
    #1 chk("single_no_req_ready", 32'(req_ready), 32'd0);
    cyc();
    chk("single_drained", 32'(rsp_valid), 32'd0);

    // Op table, back-to-back on requester 0.
    for (int k = 0; k < 13; k++) begin
      setop(0, vecs[k].sel, vecs[k].a, vecs[k].b);
      req_valid = 2'b01;
      #1 chk($sformatf("op%0d_req_ready", k), 32'(req_ready), 32'd1);
      cyc();
      chk($sformatf("op%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("op%0d_rsp_data", k), rsp_data, vecs[k].r);
    end

    // pc + imm operand selection.
    setop(0, 4'b1000, 32'd0, 32'd0);
    req_asel[0]     = 1'b1;
    req_bsel[0]     = 1'b1;
    req_pc[DW-1:0]  = 32'h100;
    req_imm[DW-1:0] = 32'h10;
    cyc();
    chk("pc_imm_rsp_data", rsp_data, 32'h110);

    // Requester 1 alone: 10 - 3.
    setop(1, 4'b0100, 32'd10, 32'd3);
    req_valid = 2'b10;
    #1 chk("req1_req_ready", 32'(req_ready), 32'd2);
    cyc();
    chk("req1_rsp_valid", 32'(rsp_valid), 32'd2);
    chk("req1_rsp_data", rsp_data, 32'd7);

    // Continuous conflict with rsp_ready = 11.
    setop(0, 4'b1000, 32'd1, 32'd1);
    req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
`ifdef ALU_ARBITER_RR_EN
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      #1 chk($sformatf("conflict%0d_req_ready", c), 32'(req_ready), 32'(exp_g));
      cyc();
      chk($sformatf("conflict%0d_rsp_valid", c), 32'(rsp_valid), 32'(exp_g));
      chk($sformatf("conflict%0d_rsp_data", c), rsp_data, (exp_g == 2'b01) ? 32'd2 : 32'd7);
    end
    req_valid = 2'b00;
    cyc();
    chk("conflict_drained", 32'(rsp_valid), 32'd0);

    // Backpressure: 20 + 22 held, requester 1 pending.
    rsp_ready = 2'b00;
    setop(0, 4'b1000, 32'd20, 32'd22);
    req_valid = 2'b01;
    #1 chk("bp_accept", 32'(req_ready), 32'd1);
    cyc();
    req_valid = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'd0);
      cyc();
      chk($sformatf("bp%0d_rsp_valid", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_rsp_data", c), rsp_data, 32'd42);
    end
    rsp_ready = 2'b01;
    #1 chk("bp_same_cycle_accept", 32'(req_ready), 32'd2);
    cyc();
    chk("bp_next_rsp_valid", 32'(rsp_valid), 32'd2);
    chk("bp_next_rsp_data", rsp_data, 32'd7);
    req_valid = 2'b00;
    rsp_ready = 2'b10;
    cyc();
    chk("bp_drained", 32'(rsp_valid), 32'd0);

    // Request withdrawn before grant leaves no trace.
    rsp_ready = 2'b00;
    setop(0, 4'b1000, 32'd1, 32'd2);
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b10;
    cyc();
    cyc();
    chk("drop_held_data", rsp_data, 32'd3);
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    #1 chk("drop_req_ready", 32'(req_ready), 32'd0);
    cyc();
    chk("drop_rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset pulsed while holding a result.
    rsp_ready = 2'b00;
    setop(0, 4'b1000, 32'd4, 32'd4);
    req_valid = 2'b01;
    cyc();
    chk("rst_hold_rsp_valid", 32'(rsp_valid), 32'd1);
    req_valid = 2'b11;
    reset_n   = 1'b0;
    #1;
    chk("rst_async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_async_rsp_data", rsp_data, 32'd0);
    chk("rst_async_req_ready", 32'(req_ready), 32'd0);
    cyc();
    reset_n   = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    cyc();
    chk("rst_release_rsp_valid0", 32'(rsp_valid), 32'd0);
    cyc();
    chk("rst_release_rsp_valid1", 32'(rsp_valid), 32'd0);
    setop(0, 4'b1000, 32'd1, 32'd1);
    req_valid = 2'b11;
    #1 chk("rst_first_conflict", 32'(req_ready), 32'd1);
    cyc();
    chk("rst_first_rsp_data", rsp_data, 32'd2);
    req_valid = 2'b00;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, datapath width; all operand and result ports are DATA_W bits.
REQ-002 The block SHALL have port clock, input, 1, single clock, all state on rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, 2, per-requester request valid (bit i = requester i).
REQ-005 The block SHALL have port req_ready, output, 2, per-requester request accepted this cycle.
REQ-006 The block SHALL have port req_asel, input, 2, per-requester A-operand select (1 = pc, 0 = rs1).
REQ-007 The block SHALL have port req_bsel, input, 2, per-requester B-operand select (1 = imm, 0 = rs2).
REQ-008 The block SHALL have port req_alusel, input, 8, per-requester 4-bit ALUSel; bits [4i+3:4i].
REQ-009 The block SHALL have ports req_pc, req_rs1, req_rs2 and req_imm, each input, 2*DATA_W, per-requester operands; requester i occupies slice [DATA_W*i +: DATA_W].
REQ-010 The block SHALL have port rsp_valid, output, 2, result valid, one-hot to the owning requester.
REQ-011 The block SHALL have port rsp_ready, input, 2, per-requester result accept.
REQ-012 The block SHALL have port rsp_data, output, DATA_W, result for the requester flagged in rsp_valid.

Function
REQ-013 The block SHALL share one ALU datapath between two requesters; a transfer occurs on req_valid[i] & req_ready[i] at a rising edge.
REQ-014 The block SHALL implement FSM states IDLE (no result held) and HOLD (result registered, awaiting rsp handshake).
REQ-015 The block SHALL allow acceptance, meaning accept_ok, in IDLE, or in HOLD when rsp_valid[k] & rsp_ready[k] holds for the owner k in the same cycle.
REQ-016 The block SHALL assert req_ready as the one-hot grant when accept_ok and any req_valid is set, and as 0 otherwise; req_ready may depend combinationally on req_valid and rsp_ready.
REQ-017 The block SHALL register the ALU result of the granted request on the accepting edge; rsp_valid asserts the next cycle (latency 1), giving a throughput of 1 op/cycle under continuous rsp_ready.
REQ-018 The block SHALL hold rsp_data and rsp_valid stable while rsp_valid & !rsp_ready.
REQ-019 FSM transitions: IDLE->HOLD on accept; HOLD->IDLE on rsp handshake without a new accept; HOLD->HOLD on rsp handshake with a same-cycle accept (new owner/result) or when no handshake occurs.
REQ-020 The block SHALL compute results per ALUSel: 1000 add, 0100 sub, 1110 sll, 0111 srl, 1011 sra, 1100 slt signed, 0110 sltu, 1111 and, 0000 or, 1010 xor, 0001/0011 add, 0010 add with bit0 cleared, 1001 pass B; any other code gives 0; shift amount = B[4:0]; all arithmetic wraps modulo 2^DATA_W.
REQ-021 The block SHALL drop a request whose req_valid deasserts before grant, without side effects.

Reset
REQ-022 While reset_n = 0, the block SHALL hold state = IDLE, rsp_valid = 0, rsp_data = 0, owner = 0 and last_grant = 1, with req_ready = 0.
REQ-023 Reset asserted while in HOLD SHALL discard the held result; no rsp_valid appears after reset release until a new accept.

Configuration
REQ-024 With macro ALU_ARBITER_RR_EN defined, the block SHALL arbitrate round-robin: on conflict, grant the requester not equal to last_grant; last_grant updates on every accept.
REQ-025 Without ALU_ARBITER_RR_EN, the block SHALL use fixed priority (requester 0 always wins a conflict), and last_grant SHALL be absent.

Structure
REQ-026 The ALUSel encodings, FSM state enum and DATA_W default SHALL reside in shared package alu_pkg.
REQ-027 The combinational datapath SHALL be one sub-module, alu_arb_dp (operand muxing plus op decode), instantiated once; arbitration and FSM SHALL reside in alu_arbiter.

Verification
REQ-028 Bench SHALL cover: single op, req0 add rs1=5, rs2=7, bsel=0, rsp_ready=1 -> req_ready=01 the same cycle, rsp_valid=01 and rsp_data=12 the next cycle.
REQ-029 Bench SHALL cover: both valid every cycle with RR_EN and rsp_ready=11 -> grants 01,10,01,10; rsp_data alternates, one result per cycle.
REQ-030 Bench SHALL cover: the same conflict without RR_EN -> req_ready=01 every cycle, requester 1 starved.
REQ-031 Bench SHALL cover: backpressure, result held with rsp_ready=00 for 3 cycles -> rsp_data stable, req_ready=00; rsp_ready=01 with req1 pending -> same-cycle accept, rsp_valid=10 the next cycle.
REQ-032 Bench SHALL cover: ops sra rs1=0x80000000 by 4 -> 0xF8000000; slt -1<1 -> 1; sltu 0xFFFFFFFF<1 -> 0; jalr-add 3+4 -> 6; ALUSel 0101 -> 0.
REQ-033 Bench SHALL cover: reset_n pulsed low mid-HOLD -> rsp_valid=0 immediately (asynchronously), the held result never delivered, first conflict after release grants requester 0.
